// File: rtl/mlp_weight_bank_mem_if.sv
// Loader stream and parallel read bus for the MLP weight bank store.
// master drives loads/reads; slave is the memory.
interface mlp_weight_bank_mem_if #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                            load_start;
    logic                            in_valid;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            in_ready;
    logic                            load_done;
    logic                            weights_valid;
    logic                            busy;
    logic                            rd_en;
    logic [ADDR_WIDTH-1:0]           rd_addr;
    logic                            rd_valid;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;

    modport master (
        output load_start, in_valid, in_data, rd_en, rd_addr,
        input  in_ready, load_done, weights_valid, busy,
        input  rd_valid, rd_data
    );

    modport slave (
        input  load_start, in_valid, in_data, rd_en, rd_addr,
        output in_ready, load_done, weights_valid, busy,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/mlp_weight_bank_mem.sv
// Multi-bank MLP weight store: streamed address-major load, full-column read.
// Optional per-word even parity with sticky error: MLP_WEIGHT_MEM_PARITY_EN.
module mlp_weight_bank_mem #(
    parameter int NUM_BANKS  = 4,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
`ifdef MLP_WEIGHT_MEM_PARITY_EN
    output logic parity_err,
`endif
    mlp_weight_bank_mem_if.slave bus
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
`ifdef MLP_WEIGHT_MEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [BW-1:0]         LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [BW-1:0]           bank_cnt;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic                    in_ready;
    logic                    accept;
    logic                    last;
    logic                    rd_fire;
    logic                    addr_ok;
    logic                    load_done;
    logic                    weights_valid;
    logic                    rd_valid;
    logic [MW-1:0]           wword;
    logic [MW-1:0]           mem [NUM_BANKS][DEPTH];
    logic [MW-1:0]           lane_q [NUM_BANKS];
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_word;

    always_comb begin
        state_nx = state;
        in_ready = (state == LOAD) && !bus.load_start;
        accept   = in_ready && bus.in_valid;
        last     = accept && (bank_cnt == LAST_BANK)
                   && (addr_cnt == LAST_ADDR);
        unique case (state)
            IDLE:    if (bus.load_start) state_nx = LOAD;
            LOAD:    if (last)           state_nx = READY;
            READY:   if (bus.load_start) state_nx = LOAD;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // bank_cnt is the fast index, so words land address-major across banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt      <= '0;
            addr_cnt      <= '0;
            load_done     <= 1'b0;
            weights_valid <= 1'b0;
        end else begin
            load_done <= last;
            if (bus.load_start) begin
                bank_cnt      <= '0;
                addr_cnt      <= '0;
                weights_valid <= 1'b0;
            end else if (accept) begin
                if (bank_cnt == LAST_BANK) begin
                    bank_cnt <= '0;
                    addr_cnt <= (addr_cnt == LAST_ADDR) ? '0
                                : addr_cnt + ADDR_WIDTH'(1);
                end else begin
                    bank_cnt <= bank_cnt + BW'(1);
                end
                if (last) weights_valid <= 1'b1;
            end
        end
    end

`ifdef MLP_WEIGHT_MEM_PARITY_EN
    assign wword = {^bus.in_data, bus.in_data};
`else
    assign wword = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[bank_cnt][addr_cnt] <= wword;
    end

    assign rd_fire = bus.rd_en && (state != LOAD);
    assign addr_ok = {1'b0, bus.rd_addr} < DEPTH_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) lane_q[b] <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    lane_q[b] <= addr_ok ? mem[b][bus.rd_addr] : '0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            rd_word[b*DATA_WIDTH +: DATA_WIDTH] = lane_q[b][DATA_WIDTH-1:0];
    end

`ifdef MLP_WEIGHT_MEM_PARITY_EN
    logic                 ok_q;
    logic [NUM_BANKS-1:0] lane_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ok_q <= 1'b0;
        else if (rd_fire) ok_q <= addr_ok;
    end

    always_comb begin
        lane_bad = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            lane_bad[b] = ok_q && (^lane_q[b]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           parity_err <= 1'b0;
        else if (bus.load_start)           parity_err <= 1'b0;
        else if (rd_valid && |lane_bad)    parity_err <= 1'b1;
    end
`endif

    assign bus.in_ready      = in_ready;
    assign bus.load_done     = load_done;
    assign bus.weights_valid = weights_valid;
    assign bus.busy          = (state == LOAD);
    assign bus.rd_valid      = rd_valid;
    assign bus.rd_data       = rd_word;
endmodule

// File: tb/tb_mlp_weight_bank_mem.sv
// Directed bench for mlp_weight_bank_mem (4 banks x 8 words x 16 bits).
// Expected columns are computed from the address-major load order.
module tb_mlp_weight_bank_mem;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef MLP_WEIGHT_MEM_PARITY_EN
    logic parity_err;
`endif

    mlp_weight_bank_mem_if #(
        .NUM_BANKS(4), .DATA_WIDTH(16), .ADDR_WIDTH(3)
    ) bus ();

    mlp_weight_bank_mem #(
        .NUM_BANKS(4), .DEPTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef MLP_WEIGHT_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] col(input logic [15:0] base,
                                        input int a);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 4; b++) v[b*16 +: 16] = base + 16'(a * 4 + b);
        return v;
    endfunction

    task automatic start_load();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] base, input bit toggle,
                        input int n, output int acc, output int rdy,
                        output int dn, output int dacc);
        int cyc;
        acc = 0; rdy = 0; dn = 0; dacc = -1; cyc = 0;
        while (acc < n && cyc < 200) begin
            bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = base + 16'(acc);
            #1;
            if (bus.in_ready) rdy++;
            if (bus.in_valid && bus.in_ready) acc++;
            step();
            cyc++;
            if (bus.load_done) begin
                dn++;
                dacc = acc;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [63:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        step();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        chk({tag, "_data"}, bus.rd_data, exp);
    endtask

    task automatic full_load(input string tag, input logic [15:0] base,
                             input bit toggle);
        int acc, rdy, dn, dacc;
        start_load();
        feed(base, toggle, 32, acc, rdy, dn, dacc);
        chk({tag, "_accepted"}, 64'(acc), 64'd32);
        if (!toggle) chk({tag, "_ready_cycles"}, 64'(rdy), 64'd32);
        chk({tag, "_done_at"}, 64'(dacc), 64'd32);
        chk({tag, "_wvalid"}, 64'(bus.weights_valid), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        step();
        if (bus.load_done) dn++;
        chk({tag, "_done_pulses"}, 64'(dn), 64'd1);
    endtask

    initial begin
        int acc, rdy, dn, dacc;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_load_done", 64'(bus.load_done), 64'd0);
        chk("rst_wvalid", 64'(bus.weights_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
        rst = 1'b0;
        step();

        bus.rd_en = 1'b1;
        bus.rd_addr = 3'd0;
        step();
        bus.rd_en = 1'b0;
        chk("idle_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("idle_wvalid", 64'(bus.weights_valid), 64'd0);
        step();
        chk("idle_rd_valid_drop", 64'(bus.rd_valid), 64'd0);

        full_load("ld1", 16'h0000, 1'b0);
        rd("ld1_a2", 3'd2, 64'h000B_000A_0009_0008);

        full_load("ld2", 16'h0000, 1'b1);
        rd("ld2_a2", 3'd2, 64'h000B_000A_0009_0008);
        rd("ld2_a5", 3'd5, col(16'h0000, 5));

        start_load();
        chk("ld3_wvalid_clr", 64'(bus.weights_valid), 64'd0);
        feed(16'h0000, 1'b0, 10, acc, rdy, dn, dacc);
        chk("ld3_partial", 64'(acc), 64'd10);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'hDEAD;
        #1;
        chk("ld3_restart_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        chk("ld3_restart_busy", 64'(bus.busy), 64'd1);
        feed(16'h1000, 1'b0, 32, acc, rdy, dn, dacc);
        chk("ld3_accepted", 64'(acc), 64'd32);
        chk("ld3_done_at", 64'(dacc), 64'd32);
        chk("ld3_wvalid", 64'(bus.weights_valid), 64'd1);
        rd("ld3_a0", 3'd0, 64'h1003_1002_1001_1000);
        rd("ld3_a2", 3'd2, col(16'h1000, 2));

        start_load();
        bus.rd_en = 1'b1;
        bus.rd_addr = 3'd1;
        step();
        chk("load_rd_valid0", 64'(bus.rd_valid), 64'd0);
        step();
        chk("load_rd_valid1", 64'(bus.rd_valid), 64'd0);
        chk("load_rd_hold", bus.rd_data, col(16'h1000, 2));
        bus.rd_en = 1'b0;
        feed(16'h0000, 1'b0, 32, acc, rdy, dn, dacc);
        chk("ld4_accepted", 64'(acc), 64'd32);
        bus.rd_en = 1'b1;
        bus.rd_addr = 3'd7;
        step();
        chk("b2b_a7_valid", 64'(bus.rd_valid), 64'd1);
        chk("b2b_a7_data", bus.rd_data, 64'h001F_001E_001D_001C);
        bus.rd_addr = 3'd0;
        step();
        bus.rd_en = 1'b0;
        chk("b2b_a0_valid", 64'(bus.rd_valid), 64'd1);
        chk("b2b_a0_data", bus.rd_data, 64'h0003_0002_0001_0000);
        step();
        chk("b2b_valid_drop", 64'(bus.rd_valid), 64'd0);
        chk("b2b_data_hold", bus.rd_data, 64'h0003_0002_0001_0000);

        start_load();
        feed(16'h3000, 1'b0, 20, acc, rdy, dn, dacc);
        chk("ld5_partial", 64'(acc), 64'd20);
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("arst_wvalid", 64'(bus.weights_valid), 64'd0);
        chk("arst_rd_data", bus.rd_data, 64'd0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        full_load("ld6", 16'h2000, 1'b0);
        rd("ld6_a5", 3'd5, col(16'h2000, 5));
        rd("ld6_a0", 3'd0, col(16'h2000, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mlp_weight_bank_mem.md
Name: mlp_weight_bank_mem

Overview:
- Multi-bank weight store for one MLP layer, one bank per perceptron.
- NUM_BANKS banks of DEPTH words each.
- Loaded by a valid/ready word stream with an internal auto-incrementing address; no per-word addressing by the loader.
- Read side returns one weight from every bank in parallel, so the MAC array gets a full column per cycle.

Parameters:
- NUM_BANKS, 4: number of perceptrons/banks; must be >= 1.
- DEPTH, 8: weights per bank; any value >= 2, not required to be a power of two.
- DATA_WIDTH, 16: width of each weight (fixed-point).
- ADDR_WIDTH, $clog2(DEPTH): width of the read address.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  pulse: begin or restart a full load.
- in_valid  in  1  loader word valid.
- in_data  in  DATA_WIDTH  loader weight word.
- in_ready  out  1  word accepted on a cycle with in_valid & in_ready.
- load_done  out  1  one-cycle pulse after the last word is accepted.
- weights_valid  out  1  level; a complete load has finished since reset or the last load_start.
- busy  out  1  high while in LOAD.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  word index within every bank.
- rd_valid  out  1  rd_data valid.
- rd_data  out  NUM_BANKS*DATA_WIDTH  bank b at bits [b*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async, rst=1):
  - State IDLE; bank_cnt=0, addr_cnt=0.
  - in_ready=0, load_done=0, weights_valid=0, busy=0, rd_valid=0, rd_data=0.
  - Memory contents are not cleared.
- States and transitions:
  - IDLE: load_start -> LOAD.
  - LOAD: last word accepted -> READY.
  - READY: load_start -> LOAD.
  - load_start while in LOAD restarts: counters go to 0, weights_valid stays 0, and words already written are simply overwritten later.
- Entering LOAD: counters cleared and weights_valid cleared on the same edge.
- in_ready = (state==LOAD) & ~load_start.
  - Combinational from registered state.
  - When load_start and in_valid are high together, the word is not accepted.
- Load order is address-major. Word k (k = 0..NUM_BANKS*DEPTH-1) is written to bank k mod NUM_BANKS, address k div NUM_BANKS.
  - Implemented with two counters: bank_cnt wraps at NUM_BANKS-1 and increments addr_cnt.
  - No multiplier or divider.
  - Write is synchronous: it occurs on the accepting edge.
- Last word is bank_cnt==NUM_BANKS-1 and addr_cnt==DEPTH-1. On its accepting edge:
  - state -> READY;
  - load_done=1 for exactly one cycle;
  - weights_valid=1;
  - busy=0;
  - counters return to 0.
- in_valid with in_ready=0 (IDLE, READY, or the load_start cycle): ignored, no write.
- Reads:
  - Allowed in IDLE and READY; rd_en in LOAD is ignored (rd_valid=0, rd_data holds).
  - Latency 1: rd_en at edge N gives rd_valid=1 and rd_data registered after edge N.
  - rd_valid=0 on cycles after rd_en=0; rd_data holds its last value.
  - Back-to-back reads give one result per cycle.
- rd_addr >= DEPTH (non-power-of-two DEPTH): all lanes return 0 and rd_valid=1.
- Reads in IDLE before any load return the current memory contents, with weights_valid=0 flagging them untrusted.
- Memory is inferred block RAM: one synchronous write port and one synchronous read port per bank.
  - Write and read never occur in the same cycle, because reads are ignored in LOAD.
- Reset mid-LOAD: returns to IDLE, counters 0, weights_valid=0; partially written contents remain.

Optional Feature:
- Macro: MLP_WEIGHT_MEM_PARITY_EN.
- With the macro defined:
  - Each stored word carries one extra even-parity bit, computed from in_data at write time.
  - On every valid read, parity is rechecked per lane.
  - New output port parity_err (1 bit) is a sticky flag: set the cycle rd_valid=1 with any lane mismatch (lanes with rd_addr>=DEPTH excluded).
  - parity_err is cleared by rst or load_start.
  - rd_data is unaffected.
- Without the macro: no parity storage, no parity_err port, memory width exactly DATA_WIDTH.

Test Plan (NUM_BANKS=4, DEPTH=8, DATA_WIDTH=16):
1. Reset then rd_en=1 with rd_addr=0:
   - after reset: all outputs 0;
   - read: rd_valid=1 one cycle later, weights_valid=0.
2. load_start, then 32 words 0x0000..0x001F with in_valid held high:
   - in_ready high for 32 cycles;
   - load_done pulses once after word 31;
   - weights_valid=1;
   - read rd_addr=2 -> rd_data = {0x000B,0x000A,0x0009,0x0008} (bank3..bank0).
3. Same load with in_valid toggling every other cycle:
   - identical memory contents;
   - load_done exactly after the 32nd accepted word.
4. load_start asserted after 10 words, with in_valid high that same cycle:
   - that word is not accepted;
   - a fresh load of 32 words 0x1000+k follows;
   - rd_addr=0 -> {0x1003,0x1002,0x1001,0x1000}.
5. rd_en during LOAD -> rd_valid stays 0. After READY:
   - back-to-back reads of addr 7 then 0 give rd_valid high two cycles with the correct values;
   - rd_addr=7 -> {0x001F,0x001E,0x001D,0x001C} after load 2.
6. Async rst asserted mid-cycle during LOAD word 20:
   - immediately busy=0, in_ready=0, weights_valid=0;
   - a later full load completes normally.
   - With MLP_WEIGHT_MEM_PARITY_EN: forcing a stored bit flip sets parity_err on the read, and load_start clears it.
